// File: rtl/risc_v_32i_pkg.sv
// Shared RV32I widths, ALU select encodings and dispatch-stage decode constants.
package risc_v_32i;

    localparam int REG_SIZE    = 32;
    localparam int REG_WIDTH   = 5;
    localparam int ALU_SEL_LEN = 4;

    localparam logic [ALU_SEL_LEN-1:0] OP_ADD = 4'd0;
    localparam logic [ALU_SEL_LEN-1:0] OP_SUB = 4'd1;
    localparam logic [ALU_SEL_LEN-1:0] OP_LSL = 4'd2;
    localparam logic [ALU_SEL_LEN-1:0] OP_LSR = 4'd3;
    localparam logic [ALU_SEL_LEN-1:0] OP_XOR = 4'd4;
    localparam logic [ALU_SEL_LEN-1:0] OP_OR  = 4'd5;
    localparam logic [ALU_SEL_LEN-1:0] OP_AND = 4'd6;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SLT     = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
    localparam logic [2:0] FUNCT3_XOR     = 3'b100;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
    localparam logic [2:0] FUNCT3_OR      = 3'b110;
    localparam logic [2:0] FUNCT3_AND     = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } dispatch_state_t;

endpackage

// File: rtl/alu_dispatch_decode.sv
// Combinational OP / OP-IMM decoder: ALU select, sign-extended I-immediate and legality.
module alu_decode
    import risc_v_32i::*;
(
    input  logic [31:0]            instr,
    output logic [ALU_SEL_LEN-1:0] alu_ctrl,
    output logic [REG_SIZE-1:0]    imm,
    output logic                   use_imm,
    output logic                   legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign unused_bits = &{1'b0, instr[19:7]};

    assign imm[11:0] = instr[31:20];
    for (genvar gi = 12; gi < REG_SIZE; gi++) begin : g_sext
        assign imm[gi] = instr[31];
    end

    always_comb begin
        alu_ctrl = OP_ADD;
        use_imm  = 1'b0;
        legal    = 1'b0;
        if (opcode == OPCODE_OP) begin
            if (funct7 == FUNCT7_BASE) begin
                legal = 1'b1;
                case (funct3)
                    FUNCT3_ADD_SUB: alu_ctrl = OP_ADD;
                    FUNCT3_SLL:     alu_ctrl = OP_LSL;
                    FUNCT3_SRL_SRA: alu_ctrl = OP_LSR;
                    FUNCT3_XOR:     alu_ctrl = OP_XOR;
                    FUNCT3_OR:      alu_ctrl = OP_OR;
                    FUNCT3_AND:     alu_ctrl = OP_AND;
                    default:        legal    = 1'b0;
                endcase
            end else if (funct7 == FUNCT7_ALT && funct3 == FUNCT3_ADD_SUB) begin
                legal    = 1'b1;
                alu_ctrl = OP_SUB;
            end
        end else if (opcode == OPCODE_OP_IMM) begin
            use_imm = 1'b1;
            legal   = 1'b1;
            case (funct3)
                FUNCT3_ADD_SUB: alu_ctrl = OP_ADD;
                FUNCT3_XOR:     alu_ctrl = OP_XOR;
                FUNCT3_OR:      alu_ctrl = OP_OR;
                FUNCT3_AND:     alu_ctrl = OP_AND;
                FUNCT3_SLL: begin
                    alu_ctrl = OP_LSL;
                    legal    = (funct7 == FUNCT7_BASE);
                end
                FUNCT3_SRL_SRA: begin
                    alu_ctrl = OP_LSR;
                    legal    = (funct7 == FUNCT7_BASE);
                end
                default:        legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/alu_dispatch.sv
// Multi-cycle issue stage: accept, read registers, drive ALU, offer write-back.
module alu_dispatch
    import risc_v_32i::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [31:0]            instr,
    output logic [4:0]             rs1_addr,
    output logic [4:0]             rs2_addr,
    input  logic [REG_SIZE-1:0]    rs1_data,
    input  logic [REG_SIZE-1:0]    rs2_data,
    output logic [REG_SIZE-1:0]    alu_a,
    output logic [REG_SIZE-1:0]    alu_b,
    output logic [ALU_SEL_LEN-1:0] alu_ctrl,
    input  logic [REG_SIZE-1:0]    alu_result,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [4:0]             wb_rd,
    output logic [REG_SIZE-1:0]    wb_data,
    output logic                   illegal
);

    dispatch_state_t        state_reg;
    logic [31:0]            instr_reg;
    logic [REG_SIZE-1:0]    alu_a_reg;
    logic [REG_SIZE-1:0]    alu_b_reg;
    logic [ALU_SEL_LEN-1:0] alu_ctrl_reg;
    logic [4:0]             wb_rd_reg;
    logic [REG_SIZE-1:0]    wb_data_reg;
    logic                   wb_valid_reg;
    logic                   illegal_reg;

    logic [31:0]            dec_instr;
    logic [ALU_SEL_LEN-1:0] dec_ctrl;
    logic [REG_SIZE-1:0]    dec_imm;
    logic                   dec_use_imm;
    logic                   dec_legal;

    // One decoder serves both the legality check at accept and operand setup in READ.
    assign dec_instr = (state_reg == IDLE) ? instr : instr_reg;

    alu_decode u_decode (
        .instr    (dec_instr),
        .alu_ctrl (dec_ctrl),
        .imm      (dec_imm),
        .use_imm  (dec_use_imm),
        .legal    (dec_legal)
    );

    assign instr_ready = rst_n && (state_reg == IDLE);
    assign rs1_addr    = instr_reg[19:15];
    assign rs2_addr    = instr_reg[24:20];
    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;
    assign alu_ctrl    = alu_ctrl_reg;
    assign wb_valid    = wb_valid_reg;
    assign wb_rd       = wb_rd_reg;
    assign wb_data     = wb_data_reg;
    assign illegal     = illegal_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            instr_reg    <= '0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_ctrl_reg <= '0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= '0;
            wb_valid_reg <= 1'b0;
            illegal_reg  <= 1'b0;
        end else begin
            illegal_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (instr_valid) begin
                        instr_reg <= instr;
                        if (dec_legal) begin
                            state_reg <= READ;
                        end else begin
                            illegal_reg <= 1'b1;
                        end
                    end
                end
                READ: begin
                    alu_a_reg    <= rs1_data;
                    alu_b_reg    <= dec_use_imm ? dec_imm : rs2_data;
                    alu_ctrl_reg <= dec_ctrl;
                    state_reg    <= EXEC;
                end
                EXEC: begin
                    wb_data_reg <= alu_result;
                    wb_rd_reg   <= instr_reg[11:7];
                    if (instr_reg[11:7] != 5'd0) begin
                        wb_valid_reg <= 1'b1;
                        state_reg    <= WB;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        wb_valid_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// Vector-table and scoreboard bench for alu_dispatch with a behavioural regfile and ALU.
module tb_alu_dispatch;
    import risc_v_32i::*;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [31:0]            instr;
    logic [4:0]             rs1_addr, rs2_addr;
    logic [REG_SIZE-1:0]    rs1_data, rs2_data;
    logic [REG_SIZE-1:0]    alu_a, alu_b;
    logic [ALU_SEL_LEN-1:0] alu_ctrl;
    logic [REG_SIZE-1:0]    alu_result;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [4:0]             wb_rd;
    logic [REG_SIZE-1:0]    wb_data;
    logic                   illegal;

    always #5 clk = ~clk;

    alu_dispatch dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal)
    );

    logic [31:0] regs [32];
    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

    always_comb begin
        case (alu_ctrl)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_LSL:  alu_result = alu_a << alu_b[REG_WIDTH-1:0];
            OP_LSR:  alu_result = alu_a >> alu_b[REG_WIDTH-1:0];
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            default: alu_result = 32'd0;
        endcase
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] v1;
        logic [31:0] v2;
        bit          ill;
        bit          wb;
        logic [3:0]  exp_ctrl;
        logic [31:0] exp_b;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    localparam int NVEC = 16;
    vec_t    vecs [NVEC];
    wb_exp_t sb_q [$];
    int      nvec = 0;
    int      nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wb_valid && wb_ready) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", {27'd0, wb_rd}, 32'd0);
            end else begin
                wb_exp_t e;
                e = sb_q.pop_front();
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_data", wb_data, e.data);
                $display("wb x%0d = 0x%08h", wb_rd, wb_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one step into cycle 1, i.e. just after the accepting edge.
    task automatic accept(input logic [31:0] w);
        int n = 0;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
        if (!instr_ready) chk("ready_timeout", 32'd0, 32'd1);
        instr       = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic load_regs(input logic [31:0] w, input logic [31:0] v1, input logic [31:0] v2);
        regs[w[24:20]] = v2;
        regs[w[19:15]] = v1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_illegal"},  32'(illegal), 32'd0);
        chk({tag, "_alu_a"},    alu_a, 32'd0);
        chk({tag, "_alu_b"},    alu_b, 32'd0);
        chk({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'd0);
        chk({tag, "_wb_rd"},    32'(wb_rd), 32'd0);
        chk({tag, "_wb_data"},  wb_data, 32'd0);
        chk({tag, "_rs1_addr"}, 32'(rs1_addr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h002081B3, 32'd5,        32'd7,        0, 1, OP_ADD, 32'd7,        5'd3,  32'd12};
        vecs[1]  = '{32'h402081B3, 32'd5,        32'd7,        0, 1, OP_SUB, 32'd7,        5'd3,  32'hFFFFFFFE};
        vecs[2]  = '{32'hFFF00293, 32'd0,        32'd0,        0, 1, OP_ADD, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFF};
        vecs[3]  = '{32'h01F09213, 32'd1,        32'd0,        0, 1, OP_LSL, 32'd31,       5'd4,  32'h80000000};
        vecs[4]  = '{32'h4020D1B3, 32'd5,        32'd7,        1, 0, OP_ADD, 32'd0,        5'd0,  32'd0};
        vecs[5]  = '{32'h00208033, 32'd5,        32'd7,        0, 0, OP_ADD, 32'd7,        5'd0,  32'd0};
        vecs[6]  = '{32'h0020C1B3, 32'h0000F0F0, 32'h00000FF0, 0, 1, OP_XOR, 32'h00000FF0, 5'd3,  32'h0000FF00};
        vecs[7]  = '{32'h0F00E313, 32'h00000F00, 32'd0,        0, 1, OP_OR,  32'h000000F0, 5'd6,  32'h00000FF0};
        vecs[8]  = '{32'h0020D3B3, 32'h80000000, 32'h00000024, 0, 1, OP_LSR, 32'h00000024, 5'd7,  32'h08000000};
        vecs[9]  = '{32'hFF00F413, 32'h12345678, 32'd0,        0, 1, OP_AND, 32'hFFFFFFF0, 5'd8,  32'h12345670};
        vecs[10] = '{32'h0020A1B3, 32'd5,        32'd7,        1, 0, OP_ADD, 32'd0,        5'd0,  32'd0};
        vecs[11] = '{32'h000011B7, 32'd0,        32'd0,        1, 0, OP_ADD, 32'd0,        5'd0,  32'd0};
        vecs[12] = '{32'h41F09213, 32'd1,        32'd0,        1, 0, OP_ADD, 32'd0,        5'd0,  32'd0};
        vecs[13] = '{32'h0020F4B3, 32'hFF00FF00, 32'h0F0F0F0F, 0, 1, OP_AND, 32'h0F0F0F0F, 5'd9,  32'h0F000F00};
        vecs[14] = '{32'h0020E533, 32'h000000FF, 32'h0000FF00, 0, 1, OP_OR,  32'h0000FF00, 5'd10, 32'h0000FFFF};
        vecs[15] = '{32'h022081B3, 32'd5,        32'd7,        1, 0, OP_ADD, 32'd0,        5'd0,  32'd0};

        for (int r = 0; r < 32; r++) regs[r] = 32'd0;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = 32'd0;
        wb_ready = 1'b1;
        tick(); tick();
        chk("rst_instr_ready", 32'(instr_ready), 32'd0);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(instr_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            vec_t v;
            v = vecs[i];
            load_regs(v.instr, v.v1, v.v2);
            wb_ready = 1'b1;
            accept(v.instr);
            chk("illegal_c1", 32'(illegal), 32'(v.ill));
            if (v.ill) begin
                chk("ill_ready_c1", 32'(instr_ready), 32'd1);
                tick();
                chk("illegal_c2", 32'(illegal), 32'd0);
                chk("ill_no_wb", 32'(wb_valid), 32'd0);
            end else begin
                chk("ready_c1", 32'(instr_ready), 32'd0);
                if (v.wb) sb_q.push_back('{v.exp_rd, v.exp_data});
                tick();
                chk("alu_ctrl_c2", 32'(alu_ctrl), 32'(v.exp_ctrl));
                chk("alu_a_c2", alu_a, (v.instr[19:15] == 5'd0) ? 32'd0 : v.v1);
                chk("alu_b_c2", alu_b, v.exp_b);
                tick();
                chk("wb_valid_c3", 32'(wb_valid), 32'(v.wb));
                if (v.wb) begin
                    tick();
                    chk("wb_valid_c4", 32'(wb_valid), 32'd0);
                end
                chk("ready_after", 32'(instr_ready), 32'd1);
            end
            $display("vec %0d instr=0x%08h illegal=%0d", i, v.instr, v.ill);
        end

        // Write-back backpressure: outputs hold while wb_ready is low; offers in WB are ignored.
        load_regs(32'h002081B3, 32'd5, 32'd7);
        wb_ready = 1'b0;
        accept(32'h002081B3);
        sb_q.push_back('{5'd3, 32'd12});
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_wb_valid", 32'(wb_valid), 32'd1);
            chk("stall_wb_rd", 32'(wb_rd), 32'd3);
            chk("stall_wb_data", wb_data, 32'd12);
            chk("stall_ready", 32'(instr_ready), 32'd0);
            chk("stall_illegal", 32'(illegal), 32'd0);
            instr = 32'h4020D1B3;
            instr_valid = 1'b1;
        end
        instr_valid = 1'b0;
        wb_ready = 1'b1;
        tick();
        chk("stall_done_valid", 32'(wb_valid), 32'd0);
        chk("stall_done_ready", 32'(instr_ready), 32'd1);
        chk("stall_no_illegal", 32'(illegal), 32'd0);
        $display("stall sequence done");

        // Reset while in EXEC.
        accept(32'h002081B3);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_exec_ready", 32'(instr_ready), 32'd0);
        tick();
        chk_reset_vals("rst_exec");
        rst_n = 1'b1;
        #1;
        chk("rst_exec_idle", 32'(instr_ready), 32'd1);
        tick();
        chk("rst_exec_no_wb", 32'(wb_valid), 32'd0);
        $display("reset-in-EXEC sequence done");

        // Reset while in WB.
        wb_ready = 1'b0;
        accept(32'h002081B3);
        tick(); tick();
        chk("rst_wb_pre_valid", 32'(wb_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        chk_reset_vals("rst_wb");
        rst_n = 1'b1;
        wb_ready = 1'b1;
        #1;
        chk("rst_wb_idle", 32'(instr_ready), 32'd1);
        tick(); tick();
        chk("rst_wb_no_wb", 32'(wb_valid), 32'd0);
        $display("reset-in-WB sequence done");

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
